// File: rtl/gf4_mul_dom.sv
// Two-share DOM-indep GF(2^4) normal-basis multiplier for the masked Canright S-box.
// Consumes the 9-bit factor vectors of both operands and both shares. Each AND position
// produces two inner-domain terms and two cross-domain terms. The cross-domain terms are
// refreshed with one bit of z each. All four vectors are registered before anything
// recombines, and a linear map then produces a 4-bit product share per domain.
//
// Optional feature, selected by defining GF4_MUL_OUT_REG_EN:
//   Undefined: a single register stage, latency 1.
//   Defined:   a second stage registers the mapped 4-bit shares, latency 2. The two stages
//              form a two-entry pipeline that keeps full throughput.
module gf4_mul_dom #(
    parameter int unsigned FW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] qa0,
    input  logic [FW-1:0] qa1,
    input  logic [FW-1:0] qb0,
    input  logic [FW-1:0] qb1,
    input  logic [FW-1:0] z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    p0,
    output logic [3:0]    p1
);

    // The bit layout of the factor vector is fixed, so no other width is meaningful.
    if (FW != 9) begin : g_fw_check
        $error("gf4_mul_dom: FW must be 9");
    end

    // The linear output map from a 9-bit domain vector to a 4-bit product share.
    function automatic logic [3:0] lin_map(input logic [FW-1:0] e);
        logic [3:0] r;
        r[3] = e[4] ^ e[5] ^ e[6] ^ e[8];
        r[2] = e[3] ^ e[5] ^ e[6] ^ e[7];
        r[1] = e[1] ^ e[2] ^ e[6] ^ e[8];
        r[0] = e[0] ^ e[2] ^ e[6] ^ e[7];
        return r;
    endfunction

    logic          accept;

    // Stage-1 share registers, one per domain term.
    logic [FW-1:0] i00_d, i11_d, c01_d, c10_d;
    logic [FW-1:0] i00_q, i11_q, c01_q, c10_q;

    // Per-domain vectors after the register; the two domains never mix.
    logic [FW-1:0] e0, e1;

    // Inner and cross terms. The cross terms are masked with z before they reach a flop.
    always_comb begin
        i00_d = qa0 & qb0;
        i11_d = qa1 & qb1;
        c01_d = (qa0 & qb1) ^ z;
        c10_d = (qa1 & qb0) ^ z;
    end

    // The share registers load only on accept, so z is consumed exactly once per operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i00_q <= '0;
            i11_q <= '0;
            c01_q <= '0;
            c10_q <= '0;
        end else if (accept) begin
            i00_q <= i00_d;
            i11_q <= i11_d;
            c01_q <= c01_d;
            c10_q <= c10_d;
        end
    end

    // Each domain combines only its own inner term and its own cross term.
    always_comb begin
        e0 = i00_q ^ c01_q;
        e1 = i11_q ^ c10_q;
    end

`ifdef GF4_MUL_OUT_REG_EN

    logic       s1_valid_d, s1_valid_q;
    logic       out_valid_d, out_valid_q;
    logic       adv1, adv2;
    logic [3:0] p0_d, p1_d, p0_q, p1_q;

    // Stage 2 can take data when it is empty or being drained.
    // Stage 1 advances when it holds data and stage 2 can take it.
    always_comb begin
        adv2     = ~out_valid_q | out_ready;
        adv1     = s1_valid_q & adv2;
        in_ready = ~s1_valid_q | adv2;
        accept   = in_valid & in_ready;
    end

    // Next-state logic for the valid bits of both stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (adv1) begin
            s1_valid_d = 1'b0;
        end
        if (adv1) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Valid bits for both stages, kept separate from the share flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // The mapped shares feed the stage-2 registers, which stay separate per domain.
    always_comb begin
        p0_d = lin_map(e0);
        p1_d = lin_map(e1);
    end

    // The stage-2 share registers load only when stage 1 hands over a product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_q <= 4'h0;
            p1_q <= 4'h0;
        end else if (adv1) begin
            p0_q <= p0_d;
            p1_q <= p1_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p0        = p0_q;
    assign p1        = p1_q;

`else

    logic out_valid_d, out_valid_q;

    // in_ready depends only on the output state and out_ready, never on in_valid.
    always_comb begin
        in_ready = ~out_valid_q | out_ready;
        accept   = in_valid & in_ready;
    end

    // A new accept keeps out_valid high, which gives back-to-back transfers without a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    // The map is linear per domain and is driven only by flops.
    always_comb begin
        p0 = lin_map(e0);
        p1 = lin_map(e1);
    end

    assign out_valid = out_valid_q;

`endif

endmodule
